// File: rtl/ppi_port_a_strobed.sv
`default_nettype none
// ============================================================================
// Module      : ppi_port_a_strobed
// Description : 8255A port A in strobed (mode 1) input or output operation,
//               with IBF / OBF_n / INTR handshake and synchronised strobes.
//               Optional macro PPI_PA_OVERRUN_EN: keep first data and flag
//               overrun on a strobe while the input buffer is still full.
// Revision    : 1.0 - initial release
// ============================================================================
module ppi_port_a_strobed #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dir_out,
    input  logic             cfg_wr,
    input  logic             wr_pulse,
    input  logic             rd_pulse,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    input  logic             inte_wr,
    input  logic             inte_val,
    input  logic [WIDTH-1:0] pa_in,
    output logic [WIDTH-1:0] pa_out,
    output logic             pa_oe,
    input  logic             stb_n,
    input  logic             ack_n,
    output logic             ibf,
    output logic             obf_n,
    output logic             intr,
    output logic             ovr
);

    // IDLE doubles as EMPTY in output mode
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_FULL   = 2'd1;
    localparam logic [1:0] c_ST_ACKING = 2'd2;

    logic [SYNC_STAGES-1:0] r_stb_sync;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic [WIDTH-1:0]       r_pa_sync [SYNC_STAGES];
    logic                   r_stb_prev;
    logic                   r_ack_prev;

    logic [1:0]             r_state;
    logic [WIDTH-1:0]       r_in_latch;
    logic [WIDTH-1:0]       r_out_latch;
    logic                   r_ibf;
    logic                   r_obf_n;
    logic                   r_intr;
    logic                   r_inte;

    logic                   w_stb_s;
    logic                   w_ack_s;
    logic                   w_stb_fall;
    logic                   w_stb_rise;
    logic                   w_ack_fall;
    logic                   w_ack_rise;
    logic                   w_capture;
    logic [WIDTH-1:0]       w_pa_d;

    // pa_in rides through the same depth as stb_n so data lines up with the edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb_sync <= '1;
            r_ack_sync <= '1;
            r_stb_prev <= 1'b1;
            r_ack_prev <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_pa_sync[i] <= '0;
            end
        end else begin
            r_stb_sync   <= {r_stb_sync[SYNC_STAGES-2:0], stb_n};
            r_ack_sync   <= {r_ack_sync[SYNC_STAGES-2:0], ack_n};
            r_stb_prev   <= w_stb_s;
            r_ack_prev   <= w_ack_s;
            r_pa_sync[0] <= pa_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_pa_sync[i] <= r_pa_sync[i-1];
            end
        end
    end

    assign w_stb_s    = r_stb_sync[SYNC_STAGES-1];
    assign w_ack_s    = r_ack_sync[SYNC_STAGES-1];
    assign w_pa_d     = r_pa_sync[SYNC_STAGES-1];
    assign w_stb_fall = r_stb_prev & ~w_stb_s;
    assign w_stb_rise = ~r_stb_prev & w_stb_s;
    assign w_ack_fall = r_ack_prev & ~w_ack_s;
    assign w_ack_rise = ~r_ack_prev & w_ack_s;

`ifdef PPI_PA_OVERRUN_EN
    logic r_ovr;
    logic w_overrun;

    // a read in the same cycle frees the buffer, so that strobe is a capture
    assign w_capture = w_stb_fall & (~r_ibf | rd_pulse);
    assign w_overrun = w_stb_fall & r_ibf & ~rd_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
        end else if (cfg_wr) begin
            r_ovr <= 1'b0;
        end else if (!dir_out && w_overrun) begin
            r_ovr <= 1'b1;
        end
    end

    assign ovr = r_ovr;
`else
    assign w_capture = w_stb_fall;
    assign ovr       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_in_latch  <= '0;
            r_out_latch <= '0;
            r_ibf       <= 1'b0;
            r_obf_n     <= 1'b1;
            r_intr      <= 1'b0;
            r_inte      <= 1'b0;
        end else if (cfg_wr) begin
            r_state     <= c_ST_IDLE;
            r_in_latch  <= '0;
            r_out_latch <= '0;
            r_ibf       <= 1'b0;
            r_obf_n     <= 1'b1;
            r_intr      <= 1'b0;
            r_inte      <= 1'b0;
        end else begin
            if (inte_wr) begin
                r_inte <= inte_val;
            end
            if (!dir_out) begin
                if (w_capture) begin
                    r_in_latch <= w_pa_d;
                    r_ibf      <= 1'b1;
                    r_state    <= c_ST_FULL;
                    if (rd_pulse) begin
                        r_intr <= 1'b0;
                    end
                end else if (rd_pulse) begin
                    r_ibf   <= 1'b0;
                    r_intr  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end else if (w_stb_rise && r_ibf && r_inte) begin
                    r_intr <= 1'b1;
                end
            end else begin
                // a write always wins over a coincident acknowledge edge
                if (wr_pulse) begin
                    r_out_latch <= bus_in;
                    r_obf_n     <= 1'b0;
                    r_intr      <= 1'b0;
                    r_state     <= c_ST_FULL;
                end else begin
                    case (r_state)
                        c_ST_FULL: begin
                            if (w_ack_fall) begin
                                r_obf_n <= 1'b1;
                                r_state <= c_ST_ACKING;
                            end
                        end
                        c_ST_ACKING: begin
                            if (w_ack_rise) begin
                                r_intr  <= r_inte;
                                r_state <= c_ST_IDLE;
                            end
                        end
                        default: begin
                            r_state <= c_ST_IDLE;
                        end
                    endcase
                end
            end
            // dropping INTE withdraws any pending request
            if (inte_wr && !inte_val) begin
                r_intr <= 1'b0;
            end
        end
    end

    assign pa_oe   = dir_out;
    assign pa_out  = r_out_latch;
    assign bus_out = dir_out ? r_out_latch : r_in_latch;
    assign ibf     = r_ibf;
    assign obf_n   = r_obf_n;
    assign intr    = r_intr;

endmodule
`default_nettype wire

// File: tb/tb_ppi_port_a_strobed.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppi_port_a_strobed
// Description : Directed and randomised self-checking bench for port A
//               strobed mode, with a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppi_port_a_strobed;

    localparam int c_WIDTH = 8;

    logic               clk;
    logic               rst_n;
    logic               dir_out;
    logic               cfg_wr;
    logic               wr_pulse;
    logic               rd_pulse;
    logic [c_WIDTH-1:0] bus_in;
    logic [c_WIDTH-1:0] bus_out;
    logic               inte_wr;
    logic               inte_val;
    logic [c_WIDTH-1:0] pa_in;
    logic [c_WIDTH-1:0] pa_out;
    logic               pa_oe;
    logic               stb_n;
    logic               ack_n;
    logic               ibf;
    logic               obf_n;
    logic               intr;
    logic               ovr;

    int n_assert = 0;
    int n_fail   = 0;

    // transaction-level view of the port
    logic               m_ibf, m_intr, m_inte, m_ovr, m_obf_n, m_full;
    logic [c_WIDTH-1:0] m_in, m_out;

    ppi_port_a_strobed #(
        .WIDTH       (c_WIDTH),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dir_out  (dir_out),
        .cfg_wr   (cfg_wr),
        .wr_pulse (wr_pulse),
        .rd_pulse (rd_pulse),
        .bus_in   (bus_in),
        .bus_out  (bus_out),
        .inte_wr  (inte_wr),
        .inte_val (inte_val),
        .pa_in    (pa_in),
        .pa_out   (pa_out),
        .pa_oe    (pa_oe),
        .stb_n    (stb_n),
        .ack_n    (ack_n),
        .ibf      (ibf),
        .obf_n    (obf_n),
        .intr     (intr),
        .ovr      (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cfg(input logic dir);
        @(negedge clk);
        dir_out = dir;
        cfg_wr  = 1'b1;
        @(posedge clk); #1;
        cfg_wr  = 1'b0;
        m_ibf = 0; m_intr = 0; m_inte = 0; m_ovr = 0; m_obf_n = 1; m_full = 0;
        m_in = '0; m_out = '0;
    endtask

    task automatic do_rd();
        @(negedge clk);
        rd_pulse = 1'b1;
        @(posedge clk); #1;
        rd_pulse = 1'b0;
    endtask

    task automatic do_wr(input logic [c_WIDTH-1:0] d);
        @(negedge clk);
        bus_in   = d;
        wr_pulse = 1'b1;
        @(posedge clk); #1;
        wr_pulse = 1'b0;
    endtask

    task automatic do_inte(input logic v);
        @(negedge clk);
        inte_val = v;
        inte_wr  = 1'b1;
        @(posedge clk); #1;
        inte_wr  = 1'b0;
    endtask

    // full strobe: low for 4 clocks, then high for 4 clocks to let it settle
    task automatic stb_pulse(input logic [c_WIDTH-1:0] d);
        @(negedge clk);
        pa_in = d;
        stb_n = 1'b0;
        repeat (4) @(negedge clk);
        stb_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        ack_n = 1'b0;
        repeat (4) @(negedge clk);
        ack_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; dir_out = 1'b0; cfg_wr = 1'b0; wr_pulse = 1'b0; rd_pulse = 1'b0;
        bus_in = '0; inte_wr = 1'b0; inte_val = 1'b0; pa_in = '0; stb_n = 1'b1; ack_n = 1'b1;

        // reset state
        repeat (3) @(posedge clk); #1;
        check("rst_ibf", ibf, 0);
        check("rst_obf_n", obf_n, 1);
        check("rst_intr", intr, 0);
        check("rst_ovr", ovr, 0);
        check("rst_bus_out", bus_out, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("no_spurious_ibf", ibf, 0);
        end

        // strobed input with latency check
        do_inte(1'b1);
        @(negedge clk); pa_in = 8'hA5; stb_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("ibf_before_latency", ibf, 0);
        @(posedge clk); #1;
        check("ibf_latency3", ibf, 1);
        check("bus_out_a5", bus_out, 8'hA5);
        check("intr_while_stb_low", intr, 0);
        @(negedge clk); stb_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("intr_after_stb_rise", intr, 1);
        do_rd();
        check("rd_clears_ibf", ibf, 0);
        check("rd_clears_intr", intr, 0);
        check("in_latch_kept", bus_out, 8'hA5);

        // second strobe while buffer full
        stb_pulse(8'hA5);
        check("ibf_refill", ibf, 1);
        stb_pulse(8'h11);
`ifdef PPI_PA_OVERRUN_EN
        check("overrun_bus_out", bus_out, 8'hA5);
        check("overrun_ovr", ovr, 1);
`else
        check("overwrite_bus_out", bus_out, 8'h11);
        check("overwrite_ovr", ovr, 0);
`endif
        check("ibf_after_second", ibf, 1);
        do_cfg(1'b0);
        check("cfg_ibf", ibf, 0);
        check("cfg_intr", intr, 0);
        check("cfg_ovr", ovr, 0);
        check("cfg_obf_n", obf_n, 1);
        check("cfg_bus_out", bus_out, 8'h00);

        // strobed output
        do_cfg(1'b1);
        check("pa_oe_out", pa_oe, 1);
        do_inte(1'b1);
        do_wr(8'h3C);
        check("pa_out_3c", pa_out, 8'h3C);
        check("obf_n_after_wr", obf_n, 0);
        @(negedge clk); ack_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("obf_n_after_ack_fall", obf_n, 1);
        check("intr_before_ack_rise", intr, 0);
        @(negedge clk); ack_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("intr_after_ack_rise", intr, 1);
        do_wr(8'h55);
        check("wr_clears_intr", intr, 0);
        check("obf_n_wr55", obf_n, 0);

        // write coincident with the synced ack fall
        @(negedge clk); ack_n = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); bus_in = 8'h77; wr_pulse = 1'b1;
        @(posedge clk); #1; wr_pulse = 1'b0;
        check("coincident_obf_n", obf_n, 0);
        check("coincident_pa_out", pa_out, 8'h77);
        @(negedge clk); ack_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("stale_ack_rise_obf_n", obf_n, 0);
        check("stale_ack_rise_intr", intr, 0);

        // INTE clear withdraws a pending interrupt
        ack_pulse();
        check("intr_before_inte_clr", intr, 1);
        do_inte(1'b0);
        check("inte_clr_intr", intr, 0);

        // async reset in ACKING
        do_inte(1'b1);
        do_wr(8'h99);
        @(negedge clk); ack_n = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("acking_obf_n", obf_n, 1);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check("async_rst_pa_out", pa_out, 8'h00);
        check("async_rst_bus_out", bus_out, 8'h00);
        check("async_rst_obf_n", obf_n, 1);
        check("async_rst_intr", intr, 0);
        check("async_rst_ibf", ibf, 0);
        check("async_rst_ovr", ovr, 0);
        @(negedge clk); ack_n = 1'b1; rst_n = 1'b1;

        // randomised input-mode transactions
        do_cfg(1'b0);
        for (int i = 0; i < 40; i++) begin
            int unsigned  op;
            logic [c_WIDTH-1:0] d;
            op = $urandom_range(0, 3);
            d  = c_WIDTH'($urandom);
            case (op)
                0, 1: begin
                    stb_pulse(d);
`ifdef PPI_PA_OVERRUN_EN
                    if (m_ibf) m_ovr = 1'b1;
                    else       m_in  = d;
`else
                    m_in = d;
`endif
                    m_ibf = 1'b1;
                    if (m_inte) m_intr = 1'b1;
                end
                2: begin
                    do_rd();
                    m_ibf  = 1'b0;
                    m_intr = 1'b0;
                end
                default: begin
                    do_inte(d[0]);
                    m_inte = d[0];
                    if (!d[0]) m_intr = 1'b0;
                end
            endcase
            check("rnd_in_ibf", ibf, m_ibf);
            check("rnd_in_intr", intr, m_intr);
            check("rnd_in_ovr", ovr, m_ovr);
            check("rnd_in_bus_out", bus_out, m_in);
        end

        // randomised output-mode transactions
        do_cfg(1'b1);
        for (int i = 0; i < 40; i++) begin
            int unsigned  op;
            logic [c_WIDTH-1:0] d;
            op = $urandom_range(0, 3);
            d  = c_WIDTH'($urandom);
            case (op)
                0: begin
                    do_wr(d);
                    m_out   = d;
                    m_obf_n = 1'b0;
                    m_intr  = 1'b0;
                    m_full  = 1'b1;
                end
                1, 2: begin
                    ack_pulse();
                    if (m_full) begin
                        m_obf_n = 1'b1;
                        m_intr  = m_inte;
                        m_full  = 1'b0;
                    end
                end
                default: begin
                    do_inte(d[0]);
                    m_inte = d[0];
                    if (!d[0]) m_intr = 1'b0;
                end
            endcase
            check("rnd_out_obf_n", obf_n, m_obf_n);
            check("rnd_out_intr", intr, m_intr);
            check("rnd_out_pa_out", pa_out, m_out);
            check("rnd_out_bus_out", bus_out, m_out);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
